frame_pixel_source: RTL and testbench



---
 rtl/sobel_pkg.sv | 28 ++
 rtl/pixel_skid_fifo.sv | 48 ++++
 rtl/frame_pixel_source.sv | 141 ++++++++++++++
 tb/tb_frame_pixel_source.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared defaults, FSM encoding and marker layout for the Sobel front end.
// The marker struct packs as {eof, eol, sof}, with sof in the least significant bit.
package sobel_pkg;

  localparam int SOBEL_DATA_WIDTH = 8;
  localparam int SOBEL_IMG_WIDTH  = 8;
  localparam int SOBEL_IMG_HEIGHT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } marker_t;

  localparam int MARKER_W = $bits(marker_t);

  // Counter width that never collapses to zero bits for single-entry dimensions.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry skid FIFO for stream stages.
// When the FIFO is full, a push is accepted only if a pop happens in the same cycle.
module pixel_skid_fifo #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_slot [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_slot[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_slot[r_wr_ptr] <= i_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_slot[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_pixel_source.sv
// Raster pixel source: reads a frame from single-port memory and streams it with
// sof/eol/eof markers, using a two-slot skid buffer to absorb read latency.
module frame_pixel_source
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = SOBEL_DATA_WIDTH,
  parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
  parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof
);

  localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W   = cnt_width(IMG_WIDTH);
  localparam int ROW_W   = cnt_width(IMG_HEIGHT);
  localparam int ENTRY_W = DATA_WIDTH + MARKER_W;

  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(NPIX - 1);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic                  r_in_flight;
  marker_t               r_pend_mrk;

  logic [1:0]            w_occ;
  logic [2:0]            w_credit;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_issue;
  marker_t               w_issue_mrk;
  logic [ENTRY_W-1:0]    w_head;
  marker_t               w_head_mrk;

  assign w_pop = valid_out && ready_in;

  // A slot freed by this cycle's pop counts as available. This lets the source
  // sustain one pixel per cycle, and occupancy still never exceeds two.
  assign w_credit     = 3'(w_occ) + 3'(r_in_flight) - 3'(w_pop);
  assign w_issue      = (r_state == ST_ISSUE) && (w_credit < 3'd2);
  assign w_last_issue = (r_rd_idx == IDX_LAST);

  assign w_issue_mrk.sof = (r_rd_idx == '0);
  assign w_issue_mrk.eol = (r_col == COL_LAST);
  assign w_issue_mrk.eof = w_last_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_idx    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_in_flight <= 1'b0;
      r_pend_mrk  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_in_flight <= w_issue;
      if (w_issue) r_pend_mrk <= w_issue_mrk;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_state  <= ST_ISSUE;
            r_busy   <= 1'b1;
            r_rd_idx <= '0;
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            if (w_last_issue) begin
              r_state <= ST_DRAIN;
            end else begin
              r_rd_idx <= r_rd_idx + ADDR_WIDTH'(1);
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_mrk.eof) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pixel_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_in_flight),
    .i_data ({r_pend_mrk, mem_rdata}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(w_occ)
  );

  assign w_head_mrk = marker_t'(w_head[ENTRY_W-1 -: MARKER_W]);

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd_en = w_issue;
  assign mem_addr  = r_rd_idx;
  assign valid_out = (w_occ != 2'd0);
  assign pixel_out = w_head[DATA_WIDTH-1:0];
  assign sof       = w_head_mrk.sof;
  assign eol       = w_head_mrk.eol;
  assign eof       = w_head_mrk.eof;

endmodule

// File: tb/tb_frame_pixel_source.sv
// Scoreboard bench for frame_pixel_source: a 4x3 instance for the directed scenarios
// and an 8x8 default instance driven with random backpressure.
module tb_frame_pixel_source;

  typedef struct packed {
    logic       eof;
    logic       eol;
    logic       sof;
    logic [7:0] pix;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       start_s, busy_s, done_s, rd_en_s, valid_s, ready_s, sof_s, eol_s, eof_s;
  logic [3:0] addr_s;
  logic [7:0] rdata_s, pix_s;

  logic       start_d, busy_d, done_d, rd_en_d, valid_d, ready_d, sof_d, eol_d, eof_d;
  logic [5:0] addr_d;
  logic [7:0] rdata_d, pix_d;

  int checks   = 0;
  int failures = 0;

  exp_t q_s[$];
  exp_t q_d[$];
  exp_t exp_s, exp_d;
  int   hs_s = 0, done_cnt_s = 0;
  int   hs_d = 0, done_cnt_d = 0, eol_cnt_d = 0, eof_cnt_d = 0;

  frame_pixel_source #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_WIDTH(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .mem_rd_en(rd_en_s), .mem_addr(addr_s), .mem_rdata(rdata_s),
    .pixel_out(pix_s), .valid_out(valid_s), .ready_in(ready_s),
    .sof(sof_s), .eol(eol_s), .eof(eof_s)
  );

  frame_pixel_source dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
    .mem_rd_en(rd_en_d), .mem_addr(addr_d), .mem_rdata(rdata_d),
    .pixel_out(pix_d), .valid_out(valid_d), .ready_in(ready_d),
    .sof(sof_d), .eol(eol_d), .eof(eof_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memories: data only appears the cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    rdata_s <= rd_en_s ? 8'(addr_s) + 8'd16 : 8'hEE;
    rdata_d <= rd_en_d ? 8'd255 - 8'(addr_d) : 8'hEE;
  end

  // Scoreboard for the small instance: every handshake pops one expected pixel.
  always @(negedge clk) begin
    if (rst_n && done_s) done_cnt_s++;
    if (rst_n && valid_s && ready_s) begin
      hs_s++;
      checks++;
      if (q_s.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_s_extra: got pixel %0d, expected no pixel", pix_s);
      end else begin
        exp_s = q_s.pop_front();
        if (exp_t'({eof_s, eol_s, sof_s, pix_s}) !== exp_s) begin
          failures++;
          $display("[TB] FAIL sb_s_pixel: got eof/eol/sof=%b%b%b pix=%0d, expected %b%b%b pix=%0d",
                   eof_s, eol_s, sof_s, pix_s, exp_s.eof, exp_s.eol, exp_s.sof, exp_s.pix);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_d) done_cnt_d++;
    if (rst_n && valid_d && ready_d) begin
      hs_d++;
      if (eol_d) eol_cnt_d++;
      if (eof_d) eof_cnt_d++;
      checks++;
      if (q_d.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_d_extra: got pixel %0d, expected no pixel", pix_d);
      end else begin
        exp_d = q_d.pop_front();
        if (exp_t'({eof_d, eol_d, sof_d, pix_d}) !== exp_d) begin
          failures++;
          $display("[TB] FAIL sb_d_pixel: got eof/eol/sof=%b%b%b pix=%0d, expected %b%b%b pix=%0d",
                   eof_d, eol_d, sof_d, pix_d, exp_d.eof, exp_d.eol, exp_d.sof, exp_d.pix);
        end
      end
    end
  end

  task automatic push_frame_s();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.eof = (i == 11);
      e.eol = ((i % 4) == 3);
      e.sof = (i == 0);
      e.pix = 8'(i + 16);
      q_s.push_back(e);
    end
  endtask

  task automatic pulse_start_s();
    @(posedge clk); #2 start_s = 1'b1;
    @(posedge clk); #2 start_s = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_s, done_s, rd_en_s, valid_s, sof_s, eol_s, eof_s} !== 7'd0) begin
      failures++;
      $display("[TB] FAIL reset_flags_s: got %b, expected 0000000",
               {busy_s, done_s, rd_en_s, valid_s, sof_s, eol_s, eof_s});
    end
    checks++;
    if (addr_s !== 4'd0 || pix_s !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_data_s: got addr=%0d pix=%0d, expected 0 0", addr_s, pix_s);
    end
    checks++;
    if ({busy_d, done_d, rd_en_d, valid_d, sof_d, eol_d, eof_d} !== 7'd0 ||
        addr_d !== 6'd0 || pix_d !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_d: got flags=%b addr=%0d pix=%0d, expected all zero",
               {busy_d, done_d, rd_en_d, valid_d, sof_d, eol_d, eof_d}, addr_d, pix_d);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic exp_v, exp_dn;
    $display("[TB] test_stream");
    hs_s = 0; done_cnt_s = 0; ready_s = 1'b1;
    push_frame_s();
    pulse_start_s();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_v  = (k >= 3 && k <= 14);
      exp_dn = (k == 15);
      checks++;
      if (valid_s !== exp_v) begin
        failures++;
        $display("[TB] FAIL stream_valid k=%0d: got %b, expected %b", k, valid_s, exp_v);
      end
      checks++;
      if (done_s !== exp_dn) begin
        failures++;
        $display("[TB] FAIL stream_done k=%0d: got %b, expected %b", k, done_s, exp_dn);
      end
      if (k == 1) begin
        checks++;
        if (rd_en_s !== 1'b1 || busy_s !== 1'b1 || addr_s !== 4'd0) begin
          failures++;
          $display("[TB] FAIL stream_first_read: got rd_en=%b busy=%b addr=%0d, expected 1 1 0",
                   rd_en_s, busy_s, addr_s);
        end
      end
      if (k == 15) begin
        checks++;
        if (busy_s !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stream_busy_clear: got %b, expected 0", busy_s);
        end
      end
    end
    @(posedge clk); #2;
    checks++;
    if (hs_s != 12 || done_cnt_s != 1 || q_s.size() != 0) begin
      failures++;
      $display("[TB] FAIL stream_totals: got hs=%0d done=%0d left=%0d, expected 12 1 0",
               hs_s, done_cnt_s, q_s.size());
    end
  endtask

  task automatic test_backpressure();
    logic        prev_hold;
    logic [10:0] prev_val;
    int          holds;
    $display("[TB] test_backpressure");
    hs_s = 0; done_cnt_s = 0; prev_hold = 1'b0; prev_val = '0; holds = 0;
    push_frame_s();
    @(posedge clk); #2 start_s = 1'b1; ready_s = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #2 start_s = 1'b0;
      ready_s = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge clk);
      if (prev_hold) begin
        holds++;
        checks++;
        if (valid_s !== 1'b1 || {eof_s, eol_s, sof_s, pix_s} !== prev_val) begin
          failures++;
          $display("[TB] FAIL bp_hold c=%0d: got valid=%b val=%h, expected 1 %h",
                   c, valid_s, {eof_s, eol_s, sof_s, pix_s}, prev_val);
        end
      end
      prev_hold = valid_s && !ready_s;
      prev_val  = {eof_s, eol_s, sof_s, pix_s};
    end
    @(posedge clk); #2 ready_s = 1'b1;
    checks++;
    if (hs_s != 12 || done_cnt_s != 1 || q_s.size() != 0 || holds == 0) begin
      failures++;
      $display("[TB] FAIL bp_totals: got hs=%0d done=%0d left=%0d holds=%0d, expected 12 1 0 >0",
               hs_s, done_cnt_s, q_s.size(), holds);
    end
  endtask

  task automatic test_saturation();
    int issues;
    $display("[TB] test_saturation");
    hs_s = 0; done_cnt_s = 0; issues = 0; ready_s = 1'b0;
    push_frame_s();
    @(posedge clk); #2 start_s = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2 start_s = 1'b0;
      @(negedge clk);
      if (rd_en_s) issues++;
    end
    checks++;
    if (issues != 2) begin
      failures++;
      $display("[TB] FAIL sat_issues: got %0d reads, expected 2", issues);
    end
    checks++;
    if (rd_en_s !== 1'b0 || addr_s !== 4'd2 || valid_s !== 1'b1 || pix_s !== 8'd16 || sof_s !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_stall: got rd_en=%b addr=%0d valid=%b pix=%0d sof=%b, expected 0 2 1 16 1",
               rd_en_s, addr_s, valid_s, pix_s, sof_s);
    end
    @(posedge clk); #2 ready_s = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    checks++;
    if (hs_s != 12 || done_cnt_s != 1 || q_s.size() != 0) begin
      failures++;
      $display("[TB] FAIL sat_totals: got hs=%0d done=%0d left=%0d, expected 12 1 0",
               hs_s, done_cnt_s, q_s.size());
    end
  endtask

  task automatic test_start_ignored();
    bit pulsed;
    $display("[TB] test_start_ignored");
    hs_s = 0; done_cnt_s = 0; pulsed = 1'b0; ready_s = 1'b1;
    push_frame_s();
    pulse_start_s();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #2;
      start_s = !pulsed && (hs_s == 5);
      if (start_s) pulsed = 1'b1;
    end
    start_s = 1'b0;
    checks++;
    if (!pulsed || hs_s != 12 || done_cnt_s != 1 || q_s.size() != 0) begin
      failures++;
      $display("[TB] FAIL restart_ignored: got pulsed=%0d hs=%0d done=%0d left=%0d, expected 1 12 1 0",
               pulsed, hs_s, done_cnt_s, q_s.size());
    end
    checks++;
    if (busy_s !== 1'b0 || valid_s !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_idle: got busy=%b valid=%b, expected 0 0", busy_s, valid_s);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int bad;
    $display("[TB] test_back_to_back");
    hs_s = 0; done_cnt_s = 0; seen = 1'b0; bad = 0; ready_s = 1'b1;
    push_frame_s();
    pulse_start_s();
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #2;
      if (done_s) begin
        start_s = 1'b1;
        seen    = 1'b1;
      end
    end
    @(posedge clk); #2 start_s = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy_s || valid_s || rd_en_s) bad++;
    end
    checks++;
    if (!seen || bad != 0) begin
      failures++;
      $display("[TB] FAIL start_on_done: got seen=%0d active_cycles=%0d, expected 1 0", seen, bad);
    end
    push_frame_s();
    pulse_start_s();
    repeat (25) @(posedge clk);
    #2;
    checks++;
    if (hs_s != 24 || done_cnt_s != 2 || q_s.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_totals: got hs=%0d done=%0d left=%0d, expected 24 2 0",
               hs_s, done_cnt_s, q_s.size());
    end
  endtask

  task automatic test_reset_midframe();
    bit hit;
    $display("[TB] test_reset_midframe");
    hs_s = 0; done_cnt_s = 0; hit = 1'b0; ready_s = 1'b1;
    push_frame_s();
    pulse_start_s();
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #2;
      if (hs_s == 6) hit = 1'b1;
    end
    checks++;
    if (!hit || busy_s !== 1'b1 || valid_s !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_reach: got hit=%0d busy=%b valid=%b, expected 1 1 1", hit, busy_s, valid_s);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_s, done_s, rd_en_s, valid_s, sof_s, eol_s, eof_s} !== 7'd0 ||
        addr_s !== 4'd0 || pix_s !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got flags=%b addr=%0d pix=%0d, expected all zero",
               {busy_s, done_s, rd_en_s, valid_s, sof_s, eol_s, eof_s}, addr_s, pix_s);
    end
    q_s.delete();
    @(posedge clk); #2;
    @(posedge clk); #2 rst_n = 1'b1;
    checks++;
    if (done_cnt_s != 0) begin
      failures++;
      $display("[TB] FAIL midreset_done: got %0d done pulses, expected 0", done_cnt_s);
    end
    hs_s = 0;
    push_frame_s();
    pulse_start_s();
    repeat (25) @(posedge clk);
    #2;
    checks++;
    if (hs_s != 12 || done_cnt_s != 1 || q_s.size() != 0) begin
      failures++;
      $display("[TB] FAIL midreset_refill: got hs=%0d done=%0d left=%0d, expected 12 1 0",
               hs_s, done_cnt_s, q_s.size());
    end
  endtask

  task automatic test_default_random();
    exp_t e;
    $display("[TB] test_default_random");
    hs_d = 0; done_cnt_d = 0; eol_cnt_d = 0; eof_cnt_d = 0; ready_d = 1'b1;
    for (int i = 0; i < 64; i++) begin
      e.eof = (i == 63);
      e.eol = ((i % 8) == 7);
      e.sof = (i == 0);
      e.pix = 8'(255 - i);
      q_d.push_back(e);
    end
    @(posedge clk); #2 start_d = 1'b1;
    @(posedge clk); #2 start_d = 1'b0;
    for (int c = 0; c < 400 && done_cnt_d == 0; c++) begin
      @(posedge clk); #2 ready_d = 1'($urandom_range(0, 1));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (hs_d != 64 || q_d.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_count: got hs=%0d left=%0d, expected 64 0", hs_d, q_d.size());
    end
    checks++;
    if (eol_cnt_d != 8 || eof_cnt_d != 1 || done_cnt_d != 1) begin
      failures++;
      $display("[TB] FAIL rand_markers: got eol=%0d eof=%0d done=%0d, expected 8 1 1",
               eol_cnt_d, eof_cnt_d, done_cnt_d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_s = 1'b0; ready_s = 1'b0;
    start_d = 1'b0; ready_d = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_saturation();
    test_start_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_default_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
